fetch_prefetch_queue: RTL and testbench

- Instruction fetch stage with a prefetch buffer. It generates word-addressed PCs and reads 24-bit instructions from instruction memory over a req/ack handshake, tolerating variable memory latency.
- Fetched instructions and their PCs are buffered in a small FIFO and presented to the Fetch->Decode register via valid/ready.
- Branch redirects from Execute flush the buffer and restart fetch at the target.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/prefetch_fifo.sv | 57 +++++
 rtl/fetch_prefetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch / prefetch queue block.
//   fetch_state_t : request-tracking state of the fetch engine
//   fetch_entry_t : one prefetch entry, laid out for the default 24-bit
//                   instruction / 16-bit PC configuration
//   RESET_PC      : PC the fetch engine restarts from after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no request outstanding
    WAIT    = 2'd1,  // request outstanding, data will be kept
    DISCARD = 2'd2   // request outstanding, data is stale after a redirect
  } fetch_state_t;

  typedef struct packed {
    logic [23:0] instruction;
    logic [15:0] pc;
  } fetch_entry_t;

  localparam int unsigned RESET_PC = 0;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO for the prefetch buffer.
//   clock, reset   : clock, synchronous active-low reset
//   clear          : empties the FIFO; wins over push
//   push, wrData   : write request and data (accepted at full only with pop)
//   pop            : remove head entry
//   rdData         : head entry (combinational from storage)
//   count          : current occupancy
//   full, empty    : occupancy flags
module prefetch_fifo #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DATAWIDTH = 40
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATAWIDTH-1:0]     wrData,
  output logic [DATAWIDTH-1:0]     rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrWidth = $clog2(DEPTH);

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [PtrWidth-1:0]  wrPtr;
  logic [PtrWidth-1:0]  rdPtr;
  logic                 doPush;
  logic                 doPop;

  assign full   = (count == ($clog2(DEPTH) + 1)'(DEPTH));
  assign empty  = (count == '0);
  // Push at full is legal only when the head leaves in the same cycle.
  assign doPush = push && (!full || pop);
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrWidth'(1);
      if (doPop)  rdPtr <= rdPtr + PtrWidth'(1);
      count <= count + ($clog2(DEPTH) + 1)'(doPush) - ($clog2(DEPTH) + 1)'(doPop);
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (reset && !clear && doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage with a prefetch buffer.
//   clock, reset             : clock, synchronous active-low reset
//   takeBranch, branchTarget : redirect from Execute; flushes and restarts fetch
//   memReq, memAddr          : registered read request, held until memAck
//   memAck, memData          : read completion and returned instruction
//   instrValid, instrReady   : valid/ready towards the Fetch->Decode register
//   instruction, pc          : FIFO head entry
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned INSTRUCTIONWIDTH = 24,
  parameter int unsigned DEPTH            = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        takeBranch,
  input  logic [WIDTH-1:0]            branchTarget,
  output logic                        memReq,
  output logic [WIDTH-1:0]            memAddr,
  input  logic                        memAck,
  input  logic [INSTRUCTIONWIDTH-1:0] memData,
  output logic                        instrValid,
  input  logic                        instrReady,
  output logic [INSTRUCTIONWIDTH-1:0] instruction,
  output logic [WIDTH-1:0]            pc
);

  localparam int unsigned CountWidth = $clog2(DEPTH) + 1;
  localparam int unsigned EntryWidth = INSTRUCTIONWIDTH + WIDTH;

  fetch_state_t          state;
  logic [WIDTH-1:0]      fetchPC;
  logic [CountWidth-1:0] count;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [EntryWidth-1:0] headEntry;
  logic                  pushEn;
  logic                  popEn;
  logic                  issueOk;

  // A redirect clears the FIFO, so neither a push nor a pop may take effect with it.
  assign pushEn = (state == WAIT) && memAck && !takeBranch;
  assign popEn  = !fifoEmpty && instrReady && !takeBranch;

  // Room for the next request, counting this cycle's push and pop.
  assign issueOk = pushEn ? ((int'(count) - int'(popEn) + 1) < int'(DEPTH))
                          : (!fifoFull || popEn);

  prefetch_fifo #(
    .DEPTH    (DEPTH),
    .DATAWIDTH(EntryWidth)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (takeBranch),
    .push  (pushEn),
    .pop   (popEn),
    .wrData({memData, memAddr}),
    .rdData(headEntry),
    .count (count),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign instrValid  = !fifoEmpty;
  assign instruction = headEntry[EntryWidth-1:WIDTH];
  assign pc          = headEntry[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      fetchPC <= WIDTH'(RESET_PC);
      memReq  <= 1'b0;
      memAddr <= '0;
    end else if (takeBranch) begin
      case (state)
        IDLE: begin
          memReq  <= 1'b1;
          memAddr <= branchTarget;
          fetchPC <= branchTarget + WIDTH'(1);
          state   <= WAIT;
        end
        WAIT: begin
          if (memAck) begin
            memReq  <= 1'b1;
            memAddr <= branchTarget;
            fetchPC <= branchTarget + WIDTH'(1);
          end else begin
            // Bus must hold the old request until it is acked.
            fetchPC <= branchTarget;
            state   <= DISCARD;
          end
        end
        DISCARD: begin
          fetchPC <= branchTarget;
          if (memAck) begin
            memReq <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (issueOk) begin
            memReq  <= 1'b1;
            memAddr <= fetchPC;
            fetchPC <= fetchPC + WIDTH'(1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (memAck) begin
            if (issueOk) begin
              memAddr <= fetchPC;
              fetchPC <= fetchPC + WIDTH'(1);
            end else begin
              memReq <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (memAck) begin
            memReq <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;

  localparam int W  = 16;
  localparam int IW = 24;
  localparam int D  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          takeBranch;
  logic [W-1:0]  branchTarget;
  logic          memReq;
  logic [W-1:0]  memAddr;
  logic          memAck;
  logic [IW-1:0] memData;
  logic          instrValid;
  logic          instrReady;
  logic [IW-1:0] instruction;
  logic [W-1:0]  pc;

  fetch_prefetch_queue #(
    .WIDTH           (W),
    .INSTRUCTIONWIDTH(IW),
    .DEPTH           (D)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .takeBranch  (takeBranch),
    .branchTarget(branchTarget),
    .memReq      (memReq),
    .memAddr     (memAddr),
    .memAck      (memAck),
    .memData     (memData),
    .instrValid  (instrValid),
    .instrReady  (instrReady),
    .instruction (instruction),
    .pc          (pc)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: what is on the bus and what Decode should see, in order.
  bit              mReq;
  bit              mStale;
  logic [W-1:0]    mAddr;
  logic [W-1:0]    mPC;
  logic [IW+W-1:0] q[$];
  int              waitCnt;
  int              lat;
  bit              randLat;

  // Stimulus knobs.
  bit              rstN;
  bit              br;
  bit              ready;
  bit              stray;
  logic [W-1:0]    tgt;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue();
    mReq   = 1'b1;
    mAddr  = mPC;
    mPC    = mPC + 16'd1;
    mStale = 1'b0;
  endtask

  task automatic modelReset();
    mReq = 0; mStale = 0; mAddr = '0; mPC = '0; q.delete(); waitCnt = 0;
  endtask

  // One clock cycle: drive at negedge, check, advance the model, cross posedge.
  task automatic step();
    bit              ack;
    bit              acked;
    bit              issueNow;
    logic [IW-1:0]   data;
    logic [IW+W-1:0] head;
    ack  = mReq ? (waitCnt >= lat - 1) : stray;
    data = IW'($urandom);
    reset        = rstN;
    takeBranch   = br;
    branchTarget = tgt;
    instrReady   = ready;
    memAck       = ack;
    memData      = data;
    #1;
    chk("memReq", 40'(memReq), 40'(mReq));
    if (mReq) chk("memAddr", 40'(memAddr), 40'(mAddr));
    chk("instrValid", 40'(instrValid), 40'(q.size() > 0));
    if (q.size() > 0) begin
      head = q[0];
      chk("instruction", 40'(instruction), 40'(head[IW+W-1:W]));
      chk("pc", 40'(pc), 40'(head[W-1:0]));
    end
    if (!rstN) begin
      modelReset();
    end else begin
      acked = mReq && ack;
      if (mReq && !acked) waitCnt++;
      else begin
        waitCnt = 0;
        if (randLat) lat = $urandom_range(1, 3);
      end
      if (br) begin
        q.delete();
        mPC = tgt;
        if (!mReq || (acked && !mStale)) issue();
        else if (acked) begin mReq = 0; mStale = 0; end
        else mStale = 1'b1;
      end else begin
        issueNow = !mReq || (acked && !mStale);
        if (q.size() > 0 && ready) void'(q.pop_front());
        if (acked) begin
          if (!mStale) q.push_back({data, mAddr});
          mReq = 0;
          mStale = 0;
        end
        if (issueNow && q.size() < D) issue();
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    rstN = 0; br = 0; stray = 0;
    step();
    rstN = 1;
  endtask

  initial begin
    bit found;
    rstN = 0; br = 0; ready = 1; stray = 0; tgt = '0; lat = 1; randLat = 0;
    reset = 0; takeBranch = 0; branchTarget = '0; memAck = 0; memData = '0; instrReady = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    modelReset();
    rstN = 1;

    // Zero-wait memory, Decode always ready.
    repeat (12) step();

    // Decode stalled: the buffer fills, then fetch resumes.
    doReset();
    ready = 0;
    repeat (8) step();
    ready = 1;
    repeat (10) step();

    // Three-cycle memory.
    doReset();
    lat = 3;
    repeat (16) step();

    // Redirect while 0x0005 is outstanding.
    doReset();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (mReq && mAddr == 16'h0005 && waitCnt == 0) found = 1;
      else step();
    end
    chk("reach_0005", 40'(found), 40'(1));
    br = 1; tgt = 16'h0040;
    step();
    br = 0;
    repeat (14) step();

    // Redirect coinciding with ack and pop.
    doReset();
    lat = 1;
    repeat (5) step();
    br = 1; tgt = 16'h0123;
    step();
    br = 0;
    repeat (6) step();

    // Redirect to the top of the address space.
    br = 1; tgt = 16'hFFFF;
    step();
    br = 0;
    repeat (6) step();

    // Reset mid-request, stray ack right after release.
    lat = 3;
    repeat (4) step();
    rstN = 0;
    step();
    rstN = 1; stray = 1;
    step();
    stray = 0;
    repeat (8) step();

    // Randomised traffic.
    randLat = 1;
    for (int i = 0; i < 1500; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      br    = ($urandom_range(0, 19) == 0);
      tgt   = W'($urandom);
      stray = ($urandom_range(0, 3) == 0);
      rstN  = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
